// File: rtl/lap_stopwatch_core_if.sv
// Control and display bundle for lap_stopwatch_core: key levels in, epoch/lap view out.
interface lap_stopwatch_core_if;
    logic        run;
    logic        clear;
    logic        lap;
    logic        recall;
    logic [27:0] epoch;
    logic [27:0] lap_epoch;
    logic [4:0]  lap_count;
    logic [3:0]  lap_idx;
    logic        lap_full;
    logic        overflow;

    modport master (
        output run, clear, lap, recall,
        input  epoch, lap_epoch, lap_count, lap_idx, lap_full, overflow
    );

    modport slave (
        input  run, clear, lap, recall,
        output epoch, lap_epoch, lap_count, lap_idx, lap_full, overflow
    );
endinterface

// File: rtl/lap_stopwatch_core.sv
// Mixed-radix stopwatch with lap memory and recall pointer.
// Optional macro LAP_SPLIT_EN: laps store per-lap split time instead of absolute epoch.
module lap_stopwatch_core #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned LAP_DEPTH = 8,
    parameter int unsigned HOUR_MAX  = 99
) (
    input  logic                 clock,
    input  logic                 reset_n,
    lap_stopwatch_core_if.slave  bus
);
    localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW    = 7;
    localparam int unsigned EW    = 4 * FW;
    localparam int unsigned CW    = 5;
    localparam int unsigned IW    = 4;
    localparam int unsigned AW    = $clog2(LAP_DEPTH);

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(DIV - 1);
    localparam logic [FW-1:0]    TICK_LAST   = FW'(TICK_HZ - 1);
    localparam logic [FW-1:0]    BASE60_LAST = FW'(59);
    localparam logic [FW-1:0]    HOUR_LAST   = FW'(HOUR_MAX);
    localparam logic [EW-1:0]    EPOCH_LAST  = {HOUR_LAST, BASE60_LAST, BASE60_LAST, TICK_LAST};
    localparam logic [CW-1:0]    COUNT_FULL  = CW'(LAP_DEPTH);

    logic [PRE_W-1:0] pre_q;
    logic [EW-1:0]    time_q;
    logic [EW-1:0]    lap_epoch_q;
    logic [EW-1:0]    mem [LAP_DEPTH];
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    idx_q;
    logic             lap_q;
    logic             recall_q;
    logic             full_q;
    logic             overflow_q;

    logic             tick_c;
    logic             clear_c;
    logic             capture_c;
    logic             recall_c;
    logic             wrap_c;
    logic [EW-1:0]    time_inc_c;
    logic [EW-1:0]    cap_val_c;
    logic [IW-1:0]    idx_next_c;
`ifdef LAP_SPLIT_EN
    logic [EW-1:0]    split_q;
    logic [EW-1:0]    split_inc_c;
`endif

    // One tick of the {hour, min, sec, tick} counter; hour past HOUR_MAX wraps to 0.
    function automatic logic [EW-1:0] advance(input logic [EW-1:0] e);
        logic [FW-1:0] h, m, s, t;
        {h, m, s, t} = e;
        if (t != TICK_LAST) begin
            t = t + FW'(1);
        end else begin
            t = '0;
            if (s != BASE60_LAST) begin
                s = s + FW'(1);
            end else begin
                s = '0;
                if (m != BASE60_LAST) begin
                    m = m + FW'(1);
                end else begin
                    m = '0;
                    h = (h != HOUR_LAST) ? h + FW'(1) : '0;
                end
            end
        end
        return {h, m, s, t};
    endfunction

    always_comb begin
        tick_c     = bus.run && (pre_q == PRE_LAST);
        clear_c    = bus.clear && !bus.run;
        capture_c  = bus.lap && !lap_q && !full_q && !clear_c;
        recall_c   = bus.recall && !recall_q;
        wrap_c     = tick_c && (time_q == EPOCH_LAST);
        time_inc_c = advance(time_q);
        idx_next_c = idx_q;
        // A capture always points the display at the newest lap, overriding recall.
        if (capture_c) begin
            idx_next_c = IW'(count_q);
        end else if (recall_c) begin
            if (count_q == '0 || (CW'(idx_q) + CW'(1)) == count_q) idx_next_c = '0;
            else                                                    idx_next_c = idx_q + IW'(1);
        end
`ifdef LAP_SPLIT_EN
        split_inc_c = advance(split_q);
        cap_val_c   = split_q;
`else
        cap_val_c   = time_q;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q       <= '0;
            time_q      <= '0;
            lap_epoch_q <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            lap_q       <= 1'b0;
            recall_q    <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef LAP_SPLIT_EN
            split_q     <= '0;
`endif
        end else begin
            lap_q    <= bus.lap;
            recall_q <= bus.recall;
            if (clear_c) begin
                pre_q       <= '0;
                time_q      <= '0;
                lap_epoch_q <= '0;
                count_q     <= '0;
                idx_q       <= '0;
                full_q      <= 1'b0;
                overflow_q  <= 1'b0;
`ifdef LAP_SPLIT_EN
                split_q     <= '0;
`endif
            end else begin
                // Prescaler holds while paused so no sub-tick phase is lost.
                if (bus.run) pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
                if (tick_c)  time_q <= time_inc_c;
                if (wrap_c)  overflow_q <= 1'b1;
                lap_epoch_q <= (count_q == '0) ? '0 : mem[AW'(idx_q)];
                idx_q       <= idx_next_c;
                if (capture_c) begin
                    count_q <= count_q + CW'(1);
                    full_q  <= (count_q + CW'(1)) == COUNT_FULL;
                end
`ifdef LAP_SPLIT_EN
                if (capture_c)   split_q <= '0;
                else if (tick_c) split_q <= split_inc_c;
`endif
            end
        end
    end

    // Lap storage needs no reset; count_q qualifies every read.
    always_ff @(posedge clock) begin
        if (capture_c) mem[AW'(count_q)] <= cap_val_c;
    end

    assign bus.epoch     = time_q;
    assign bus.lap_epoch = lap_epoch_q;
    assign bus.lap_count = count_q;
    assign bus.lap_idx   = idx_q;
    assign bus.lap_full  = full_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Scoreboard bench for lap_stopwatch_core: a tick-count reference model predicts every cycle's outputs.
module tb_lap_stopwatch_core;
    localparam int CLK_FREQ  = 8;
    localparam int TICK_HZ   = 4;
    localparam int LAP_DEPTH = 4;
    localparam int HOUR_MAX  = 0;
    localparam int DIV       = CLK_FREQ / TICK_HZ;
    localparam int PERIOD    = TICK_HZ * 3600 * (HOUR_MAX + 1);

    typedef struct packed {
        logic [27:0] epoch;
        logic [27:0] lap_epoch;
        logic [4:0]  lap_count;
        logic [3:0]  lap_idx;
        logic        lap_full;
        logic        overflow;
    } out_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    lap_stopwatch_core_if bus();

    lap_stopwatch_core #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .LAP_DEPTH(LAP_DEPTH),
        .HOUR_MAX (HOUR_MAX)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    out_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: run cycles since clear, tick count at last split restart, stored laps.
    int          runcyc;
    int          split_base;
    logic [27:0] laps[$];
    int          idx;
    bit          ovf;
    bit          lap_prev;
    bit          rec_prev;
    logic [27:0] lep;

    function automatic logic [27:0] fmt(input int tt);
        int t, s, m, h;
        t = tt % TICK_HZ;
        s = (tt / TICK_HZ) % 60;
        m = (tt / (TICK_HZ * 60)) % 60;
        h = tt / (TICK_HZ * 3600);
        return {7'(h), 7'(m), 7'(s), 7'(t)};
    endfunction

    function automatic out_t sample();
        out_t o;
        o.epoch     = bus.epoch;
        o.lap_epoch = bus.lap_epoch;
        o.lap_count = bus.lap_count;
        o.lap_idx   = bus.lap_idx;
        o.lap_full  = bus.lap_full;
        o.overflow  = bus.overflow;
        return o;
    endfunction

    task automatic report(input string name, input out_t got, input out_t exp);
        $display("FAIL %s t=%0t epoch got %h exp %h | lap_epoch got %h exp %h | lap_count got %0d exp %0d | lap_idx got %0d exp %0d | lap_full got %0b exp %0b | overflow got %0b exp %0b",
                 name, $time, got.epoch, exp.epoch, got.lap_epoch, exp.lap_epoch,
                 got.lap_count, exp.lap_count, got.lap_idx, exp.lap_idx,
                 got.lap_full, exp.lap_full, got.overflow, exp.overflow);
    endtask

    task automatic model_reset();
        runcyc     = 0;
        split_base = 0;
        laps.delete();
        idx        = 0;
        ovf        = 0;
        lep        = '0;
        lap_prev   = 0;
        rec_prev   = 0;
    endtask

    // Apply inputs for the coming edge and queue the outputs expected after it.
    task automatic drive_model(input bit r, input bit c, input bit l, input bit rc);
        out_t        e;
        int          old_ticks;
        int          new_ticks;
        logic [27:0] val;
        bit          lrise;
        bit          rrise;
        bus.run    = r;
        bus.clear  = c;
        bus.lap    = l;
        bus.recall = rc;
        old_ticks  = runcyc / DIV;
        lrise      = l && !lap_prev;
        rrise      = rc && !rec_prev;
        lap_prev   = l;
        rec_prev   = rc;
        if (c && !r) begin
            runcyc     = 0;
            split_base = 0;
            laps.delete();
            idx        = 0;
            ovf        = 0;
            lep        = '0;
        end else begin
            lep = (laps.size() == 0) ? 28'd0 : laps[idx];
            if (r) runcyc++;
            new_ticks = runcyc / DIV;
            if (new_ticks >= PERIOD) ovf = 1;
            if (lrise && laps.size() < LAP_DEPTH) begin
`ifdef LAP_SPLIT_EN
                val        = fmt((old_ticks - split_base) % PERIOD);
                split_base = new_ticks;
`else
                val        = fmt(old_ticks % PERIOD);
`endif
                laps.push_back(val);
                idx = laps.size() - 1;
            end else if (rrise) begin
                idx = (laps.size() == 0) ? 0 : (idx + 1) % laps.size();
            end
        end
        e.epoch     = fmt((runcyc / DIV) % PERIOD);
        e.lap_epoch = lep;
        e.lap_count = 5'(laps.size());
        e.lap_idx   = 4'(idx);
        e.lap_full  = (laps.size() == LAP_DEPTH);
        e.overflow  = ovf;
        expq.push_back(e);
    endtask

    task automatic step(input bit r, input bit c, input bit l, input bit rc);
        @(negedge clock);
        drive_model(r, c, l, rc);
    endtask

    // Drop reset_n between edges and require every output to clear without a clock.
    task automatic do_reset();
        out_t got;
        @(negedge clock);
        #2;
        reset_n    = 1'b0;
        bus.run    = 1'b0;
        bus.clear  = 1'b0;
        bus.lap    = 1'b0;
        bus.recall = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            report("async_reset", got, '0);
        end
        model_reset();
        expq.push_back('0);
        @(negedge clock);
        reset_n = 1'b1;
        drive_model(0, 0, 0, 0);
    endtask

    task automatic pulse_lap(input int gap);
        step(1, 0, 1, 0);
        repeat (gap) step(1, 0, 0, 0);
    endtask

    task automatic pulse_recall();
        step(1, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation after each edge.
    initial begin
        out_t exp;
        out_t got;
        forever begin
            @(posedge clock);
            #2;
            if (expq.size() != 0) begin
                exp = expq.pop_front();
                got = sample();
                checks++;
                if (got !== exp) begin
                    errors++;
                    report("outputs", got, exp);
                end
            end
        end
    end

    initial begin
        bus.run    = 1'b0;
        bus.clear  = 1'b0;
        bus.lap    = 1'b0;
        bus.recall = 1'b0;
        model_reset();
        do_reset();

        // Carry from seconds into minutes, then pause and resume mid-prescale.
        repeat (TICK_HZ * 60 * DIV + 7) step(1, 0, 0, 0);
        repeat (37) step(0, 0, 0, 0);
        repeat (11) step(1, 0, 0, 0);

        // Five laps into a four-deep memory, then recall wrap over a full memory.
        for (int i = 0; i < 5; i++) pulse_lap($urandom_range(3, 40));
        for (int i = 0; i < 5; i++) pulse_recall();

        // Clear is ignored while running, honoured while stopped.
        repeat (3) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Three laps, recall wrap, lap with recall, and lap with clear.
        for (int i = 0; i < 3; i++) pulse_lap($urandom_range(5, 30));
        for (int i = 0; i < 4; i++) pulse_recall();
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Run through the hour wrap so overflow sets.
        step(0, 1, 0, 0);
        repeat (PERIOD * DIV + 40) step(1, 0, 0, ($urandom_range(0, 49) == 0));

        // Randomised mix of run, clear, lap and recall levels.
        for (int i = 0; i < 15000; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        // Async reset in the middle of a prescale period.
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        do_reset();
        repeat (5) step(1, 0, 0, 0);

        @(negedge clock);
        repeat (2) @(posedge clock);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
